// File: rtl/pwm_deadtime.sv
// Complementary half-bridge gate driver with programmable dead time,
// latched fault shutdown and a saturating swallowed-pulse counter.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   pwm_in                      single-ended PWM (sync to clk)
//   en                          output enable (0 -> both gates off)
//   dt_rise, dt_fall            dead time before pwm_h / pwm_l turn on
//   fault, fault_clr            fault request / latched fault clear
//   drop_clr                    clear of drop_cnt
//   pwm_h, pwm_l                registered high/low side gates
//   dt_active, fault_latched    status flags
//   drop_cnt                    saturating swallowed-pulse count
module pwm_deadtime #(
  parameter int DT_WIDTH   = 8,
  parameter int DROP_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pwm_in,
  input  logic                  en,
  input  logic [DT_WIDTH-1:0]   dt_rise,
  input  logic [DT_WIDTH-1:0]   dt_fall,
  input  logic                  fault,
  input  logic                  fault_clr,
  input  logic                  drop_clr,
  output logic                  pwm_h,
  output logic                  pwm_l,
  output logic                  dt_active,
  output logic                  fault_latched,
  output logic [DROP_WIDTH-1:0] drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW_ON,
    S_DT_RISE,
    S_HIGH_ON,
    S_DT_FALL,
    S_FAULT
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_pwm_s;
  logic [DT_WIDTH-1:0]   r_cnt;
  logic [DT_WIDTH-1:0]   w_cnt_next;
  logic                  w_drop;
  logic [DT_WIDTH-1:0]   w_dt_rise_ld;
  logic [DT_WIDTH-1:0]   w_dt_fall_ld;
  logic                  r_pwm_h;
  logic                  r_pwm_l;
  logic                  r_dt_active;
  logic                  r_fault_latched;
  logic [DROP_WIDTH-1:0] r_drop_cnt;

  // A zero dead time becomes one cycle so the two
  // gates never switch on the same edge.
  assign w_dt_rise_ld = (dt_rise == '0) ? DT_WIDTH'(1) : dt_rise;
  assign w_dt_fall_ld = (dt_fall == '0) ? DT_WIDTH'(1) : dt_fall;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_drop     = 1'b0;
    if (fault) begin
      w_next = S_FAULT;
    end else if (r_state == S_FAULT) begin
      if (fault_clr) w_next = S_IDLE;
    end else if (!en) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_next = r_pwm_s ? S_HIGH_ON : S_LOW_ON;
        end
        S_LOW_ON: begin
          if (r_pwm_s) begin
            w_next     = S_DT_RISE;
            w_cnt_next = w_dt_rise_ld;
          end
        end
        S_DT_RISE: begin
          w_cnt_next = r_cnt - DT_WIDTH'(1);
          if (!r_pwm_s) begin
            w_next = S_LOW_ON;
            w_drop = 1'b1;
          end else if (r_cnt == DT_WIDTH'(1)) begin
            w_next = S_HIGH_ON;
          end
        end
        S_HIGH_ON: begin
          if (!r_pwm_s) begin
            w_next     = S_DT_FALL;
            w_cnt_next = w_dt_fall_ld;
          end
        end
        S_DT_FALL: begin
          w_cnt_next = r_cnt - DT_WIDTH'(1);
          if (r_pwm_s) begin
            w_next = S_HIGH_ON;
            w_drop = 1'b1;
          end else if (r_cnt == DT_WIDTH'(1)) begin
            w_next = S_LOW_ON;
          end
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_pwm_s         <= 1'b0;
      r_cnt           <= '0;
      r_pwm_h         <= 1'b0;
      r_pwm_l         <= 1'b0;
      r_dt_active     <= 1'b0;
      r_fault_latched <= 1'b0;
    end else begin
      r_state         <= w_next;
      r_pwm_s         <= pwm_in;
      r_cnt           <= w_cnt_next;
      r_pwm_h         <= (w_next == S_HIGH_ON);
      r_pwm_l         <= (w_next == S_LOW_ON);
      r_dt_active     <= (w_next == S_DT_RISE) ||
                         (w_next == S_DT_FALL);
      r_fault_latched <= (w_next == S_FAULT);
    end
  end

  // Clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (drop_clr) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + DROP_WIDTH'(1);
    end
  end

  assign pwm_h         = r_pwm_h;
  assign pwm_l         = r_pwm_l;
  assign dt_active     = r_dt_active;
  assign fault_latched = r_fault_latched;
  assign drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed self-checking bench for pwm_deadtime.
// Each task drives one scenario and checks inline.
module tb_pwm_deadtime;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pwm_in;
  logic       en;
  logic [7:0] dt_rise;
  logic [7:0] dt_fall;
  logic       fault;
  logic       fault_clr;
  logic       drop_clr;
  logic       pwm_h;
  logic       pwm_l;
  logic       dt_active;
  logic       fault_latched;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  pwm_deadtime #(
    .DT_WIDTH  (8),
    .DROP_WIDTH(8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pwm_in       (pwm_in),
    .en           (en),
    .dt_rise      (dt_rise),
    .dt_fall      (dt_fall),
    .fault        (fault),
    .fault_clr    (fault_clr),
    .drop_clr     (drop_clr),
    .pwm_h        (pwm_h),
    .pwm_l        (pwm_l),
    .dt_active    (dt_active),
    .fault_latched(fault_latched),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    checks++;
    if ((pwm_h & pwm_l) !== 1'b0) begin
      errors++;
      $display("FAIL overlap: h=%b l=%b required not both 1 t=%0t",
               pwm_h, pwm_l, $time);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pwm_in = 1'b0; en = 1'b0;
    dt_rise = 8'd4; dt_fall = 8'd3;
    fault = 1'b0; fault_clr = 1'b0; drop_clr = 1'b0;
    #2;
    checks++;
    if ({pwm_h, pwm_l, dt_active, fault_latched, drop_cnt} !== 12'd0) begin
      errors++;
      $display("FAIL reset_async: got %b/%b/%b/%b/%0d required all 0",
               pwm_h, pwm_l, dt_active, fault_latched, drop_cnt);
    end
    repeat (2) tick();
    checks++;
    if ({pwm_h, pwm_l, dt_active, fault_latched, drop_cnt} !== 12'd0) begin
      errors++;
      $display("FAIL reset_hold: got %b/%b/%b/%b/%0d required all 0",
               pwm_h, pwm_l, dt_active, fault_latched, drop_cnt);
    end
    #3 rst_n = 1'b1;
    en = 1'b1;
    tick();
    checks++;
    if ({pwm_h, pwm_l} !== 2'b01) begin
      errors++;
      $display("FAIL idle_to_low: got h,l=%b%b required 01", pwm_h, pwm_l);
    end
  endtask

  task automatic test_rise_fall();
    logic [2:0] exp;
    dt_rise = 8'd4; dt_fall = 8'd3;
    repeat (3) tick();
    pwm_in = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      exp = {n >= 6, n < 2, (n >= 2) && (n < 6)};
      checks++;
      if ({pwm_h, pwm_l, dt_active} !== exp) begin
        errors++;
        $display("FAIL rise n=%0d: got h,l,dt=%b%b%b required %b",
                 n, pwm_h, pwm_l, dt_active, exp);
      end
    end
    pwm_in = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      exp = {n < 2, n >= 5, (n >= 2) && (n < 5)};
      checks++;
      if ({pwm_h, pwm_l, dt_active} !== exp) begin
        errors++;
        $display("FAIL fall n=%0d: got h,l,dt=%b%b%b required %b",
                 n, pwm_h, pwm_l, dt_active, exp);
      end
    end
  endtask

  task automatic test_zero_dt();
    logic [2:0] exp;
    dt_rise = 8'd0; dt_fall = 8'd0;
    pwm_in = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      tick();
      exp = {n >= 3, n < 2, n == 2};
      checks++;
      if ({pwm_h, pwm_l, dt_active} !== exp) begin
        errors++;
        $display("FAIL zdt_rise n=%0d: got h,l,dt=%b%b%b required %b",
                 n, pwm_h, pwm_l, dt_active, exp);
      end
    end
    pwm_in = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      tick();
      exp = {n < 2, n >= 3, n == 2};
      checks++;
      if ({pwm_h, pwm_l, dt_active} !== exp) begin
        errors++;
        $display("FAIL zdt_fall n=%0d: got h,l,dt=%b%b%b required %b",
                 n, pwm_h, pwm_l, dt_active, exp);
      end
    end
  endtask

  task automatic test_drop();
    logic saw_h;
    dt_rise = 8'd6;
    for (int i = 0; i < 300; i++) begin
      saw_h = 1'b0;
      pwm_in = 1'b1;
      repeat (3) begin tick(); saw_h |= pwm_h; end
      pwm_in = 1'b0;
      repeat (4) begin tick(); saw_h |= pwm_h; end
      checks++;
      if ({saw_h, pwm_l} !== 2'b01) begin
        errors++;
        $display("FAIL drop_gate i=%0d: got saw_h,l=%b%b required 01",
                 i, saw_h, pwm_l);
      end
      if (i == 0 || i == 253 || i == 254 || i == 299) begin
        checks++;
        if (drop_cnt !== ((i >= 254) ? 8'd255 : 8'(i + 1))) begin
          errors++;
          $display("FAIL drop_cnt i=%0d: got %0d required %0d", i,
                   drop_cnt, (i >= 254) ? 255 : i + 1);
        end
      end
    end
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    checks++;
    if (drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL drop_clr: got %0d required 0", drop_cnt);
    end
    pwm_in = 1'b1;
    repeat (3) tick();
    pwm_in = 1'b0;
    repeat (4) tick();
    checks++;
    if (drop_cnt !== 8'd1) begin
      errors++;
      $display("FAIL drop_one: got %0d required 1", drop_cnt);
    end
    pwm_in = 1'b1;
    repeat (3) tick();
    pwm_in = 1'b0;
    tick();
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    checks++;
    if ({pwm_l, drop_cnt} !== {1'b1, 8'd0}) begin
      errors++;
      $display("FAIL clr_wins: got l=%b cnt=%0d required l=1 cnt=0",
               pwm_l, drop_cnt);
    end
  endtask

  task automatic test_fault();
    dt_rise = 8'd2;
    pwm_in = 1'b1;
    repeat (6) tick();
    checks++;
    if ({pwm_h, pwm_l} !== 2'b10) begin
      errors++;
      $display("FAIL pre_fault: got h,l=%b%b required 10", pwm_h, pwm_l);
    end
    fault = 1'b1;
    tick();
    checks++;
    if ({pwm_h, pwm_l, fault_latched} !== 3'b001) begin
      errors++;
      $display("FAIL fault_entry: got h,l,f=%b%b%b required 001",
               pwm_h, pwm_l, fault_latched);
    end
    fault_clr = 1'b1;
    tick();
    checks++;
    if ({pwm_h, pwm_l, fault_latched} !== 3'b001) begin
      errors++;
      $display("FAIL fault_wins: got h,l,f=%b%b%b required 001",
               pwm_h, pwm_l, fault_latched);
    end
    fault_clr = 1'b0;
    fault = 1'b0;
    pwm_in = 1'b0; tick();
    pwm_in = 1'b1; tick();
    pwm_in = 1'b0; tick();
    pwm_in = 1'b1; tick();
    checks++;
    if ({pwm_h, pwm_l, fault_latched, drop_cnt} !== {3'b001, 8'd0}) begin
      errors++;
      $display("FAIL fault_hold: got h,l,f=%b%b%b cnt=%0d required 001 0",
               pwm_h, pwm_l, fault_latched, drop_cnt);
    end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    checks++;
    if ({pwm_h, pwm_l, fault_latched} !== 3'b000) begin
      errors++;
      $display("FAIL fault_exit: got h,l,f=%b%b%b required 000",
               pwm_h, pwm_l, fault_latched);
    end
    tick();
    checks++;
    if ({pwm_h, pwm_l} !== 2'b10) begin
      errors++;
      $display("FAIL fault_resume: got h,l=%b%b required 10", pwm_h, pwm_l);
    end
  endtask

  task automatic test_enable();
    dt_fall = 8'd2; dt_rise = 8'd5;
    pwm_in = 1'b0;
    repeat (6) tick();
    checks++;
    if ({pwm_h, pwm_l} !== 2'b01) begin
      errors++;
      $display("FAIL en_pre: got h,l=%b%b required 01", pwm_h, pwm_l);
    end
    pwm_in = 1'b1;
    repeat (3) tick();
    checks++;
    if ({pwm_h, pwm_l, dt_active} !== 3'b001) begin
      errors++;
      $display("FAIL en_dt: got h,l,dt=%b%b%b required 001",
               pwm_h, pwm_l, dt_active);
    end
    en = 1'b0;
    repeat (2) begin
      tick();
      checks++;
      if ({pwm_h, pwm_l, dt_active} !== 3'b000) begin
        errors++;
        $display("FAIL en_off: got h,l,dt=%b%b%b required 000",
                 pwm_h, pwm_l, dt_active);
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if ({pwm_h, pwm_l, dt_active, drop_cnt} !== {3'b100, 8'd0}) begin
      errors++;
      $display("FAIL en_on: got h,l,dt=%b%b%b cnt=%0d required 100 0",
               pwm_h, pwm_l, dt_active, drop_cnt);
    end
  endtask

  task automatic test_async_reset();
    dt_fall = 8'd10;
    pwm_in = 1'b0;
    repeat (3) tick();
    checks++;
    if (dt_active !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_dt: got dt=%b required 1", dt_active);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({pwm_h, pwm_l, dt_active, fault_latched} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_dt: got %b%b%b%b required 0000",
               pwm_h, pwm_l, dt_active, fault_latched);
    end
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if ({pwm_h, pwm_l} !== 2'b01) begin
      errors++;
      $display("FAIL rst_resume1: got h,l=%b%b required 01", pwm_h, pwm_l);
    end
    fault = 1'b1;
    tick();
    checks++;
    if (fault_latched !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_fault: got f=%b required 1", fault_latched);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({pwm_h, pwm_l, dt_active, fault_latched} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_fault: got %b%b%b%b required 0000",
               pwm_h, pwm_l, dt_active, fault_latched);
    end
    fault = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if ({pwm_h, pwm_l, fault_latched} !== 3'b010) begin
      errors++;
      $display("FAIL rst_resume2: got h,l,f=%b%b%b required 010",
               pwm_h, pwm_l, fault_latched);
    end
    dt_rise = 8'd1;
    pwm_in = 1'b1;
    repeat (3) tick();
    checks++;
    if ({pwm_h, pwm_l} !== 2'b10) begin
      errors++;
      $display("FAIL rst_resume3: got h,l=%b%b required 10", pwm_h, pwm_l);
    end
  endtask

  initial begin
    test_reset();
    test_rise_fall();
    test_zero_dt();
    test_drop();
    test_fault();
    test_enable();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
